// File: rtl/proc2v_pkg.sv
// Shared constants and word/address types for the processor-2v stack core.
package proc2v_pkg;

   localparam int          ADDR_W   = 13;
   localparam int          DATA_W   = 16;
   localparam int unsigned RESET_PC = 0;
   localparam int          MEM_LAT  = 1;

   typedef logic [ADDR_W-1:0] pc_t;
   typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/fetch_buf_fifo.sv
// First-word-fall-through FIFO that holds returned fetch words until decode accepts them.
module fetch_buf_fifo #(
   parameter int DEPTH = 3,
   parameter int WIDTH = 29,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Depth is not a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one read per cycle into the synchronous instruction
// memory, tracks in-flight reads with a tag pipe and buffers returns for decode.
module instr_fetch_unit #(
   parameter int          ADDR_W   = proc2v_pkg::ADDR_W,
   parameter int          DATA_W   = proc2v_pkg::DATA_W,
   parameter int unsigned RESET_PC = proc2v_pkg::RESET_PC,
   parameter int          MEM_LAT  = proc2v_pkg::MEM_LAT
) (
   input  logic              clka,
   input  logic              rst_n,
   input  logic              fetch_en,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] douta,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc
);

   import proc2v_pkg::*;

   localparam int DEPTH = MEM_LAT + 2;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENT_W = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               started_q;
   logic [MEM_LAT-1:0] tag_valid_vec;
   logic [ADDR_W-1:0]  tag_pc_vec [MEM_LAT];
   logic [CNT_W-1:0]   buf_count, inflight_count;
   logic               buf_empty, issue, push, pop;
   logic [ENT_W-1:0]   head;

   always_comb begin
      inflight_count = '0;
      for (int i = 0; i < MEM_LAT; i++) begin
         inflight_count = inflight_count + CNT_W'(tag_valid_vec[i]);
      end
   end

   // Credit check: every outstanding read already owns a buffer slot, so returns never overflow.
   // started_q holds off the first issue for one edge after reset release.
   assign issue = fetch_en && !redirect_valid && started_q &&
                  ((int'(buf_count) + int'(inflight_count)) < DEPTH);

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) pc_d = redirect_pc;
      else if (issue)     pc_d = pc_q + 1'b1;
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_ADDR;
         started_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         started_q <= 1'b1;
      end
   end

   // Tag pipe mirrors the memory read latency; a redirect kills every stage.
   genvar gi;
   generate
      for (gi = 0; gi < MEM_LAT; gi++) begin : g_tag
         logic              valid_q, valid_d;
         logic [ADDR_W-1:0] pc_tag_q, pc_tag_d;
         if (gi == 0) begin : g_first
            assign valid_d  = issue;
            assign pc_tag_d = pc_q;
         end else begin : g_next
            assign valid_d  = tag_valid_vec[gi-1] && !redirect_valid;
            assign pc_tag_d = tag_pc_vec[gi-1];
         end
         always_ff @(posedge clka or negedge rst_n) begin
            if (!rst_n) begin
               valid_q  <= 1'b0;
               pc_tag_q <= '0;
            end else begin
               valid_q  <= valid_d;
               pc_tag_q <= pc_tag_d;
            end
         end
         assign tag_valid_vec[gi] = valid_q;
         assign tag_pc_vec[gi]    = pc_tag_q;
      end
   endgenerate

   assign push = tag_valid_vec[MEM_LAT-1] && !redirect_valid;
   assign pop  = !buf_empty && instr_ready;

   fetch_buf_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clka),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata ({tag_pc_vec[MEM_LAT-1], douta}),
      .rdata (head),
      .count (buf_count),
      .empty (buf_empty)
   );

   assign addra       = pc_q;
   assign instr_valid = !buf_empty;
   assign {instr_pc, instr_data} = buf_empty ? '0 : head;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a one-cycle synchronous memory model.
module tb_instr_fetch_unit;
   import proc2v_pkg::*;

   localparam int DEPTH = MEM_LAT + 2;

   logic  clka = 1'b0;
   logic  rst_n;
   logic  fetch_en;
   logic  redirect_valid;
   pc_t   redirect_pc;
   pc_t   addra;
   word_t douta;
   logic  instr_valid;
   logic  instr_ready;
   word_t instr_data;
   pc_t   instr_pc;

   int n_pass  = 0;
   int n_total = 0;
   int ovf_cnt = 0;

   word_t mem [8192];

   always #5 clka = ~clka;

   always @(posedge clka) douta <= mem[addra];

   instr_fetch_unit dut (
      .clka           (clka),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .addra          (addra),
      .douta          (douta),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc)
   );

   always @(posedge clka) begin
      if (rst_n && instr_valid && instr_ready)
         $display("xfer pc=%0d data=0x%04h", instr_pc, instr_data);
   end

   always @(negedge clka) begin
      if (rst_n && dut.push && !dut.pop && (int'(dut.buf_count) == DEPTH)) ovf_cnt++;
   end

   function automatic word_t exp_word(input pc_t p);
      word_t w;
      if (p <= 13'd11) begin
         w = word_t'(p);
      end else if (p <= 13'd19) begin
         w = word_t'(p - 13'd11);
         w = w << 12;
      end else if (p == 13'd8191) begin
         w = 16'hBEEF;
      end else begin
         w = '0;
      end
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clka);
   endtask

   task automatic expect_one(input pc_t p);
      chk($sformatf("valid@pc%0d", p), 32'(instr_valid), 32'd1);
      chk($sformatf("pc@pc%0d", p), 32'(instr_pc), 32'(p));
      chk($sformatf("data@pc%0d", p), 32'(instr_data), 32'(exp_word(p)));
   endtask

   task automatic expect_seq(input pc_t start, input int n);
      pc_t p = start;
      for (int k = 0; k < n; k++) begin
         expect_one(p);
         tick();
         p = p + 13'd1;
      end
   endtask

   task automatic do_redirect(input pc_t target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
      chk("redir_addra", 32'(addra), 32'(target));
      chk("redir_gap1", 32'(instr_valid), 32'd0);
      tick();
      chk("redir_gap2", 32'(instr_valid), 32'd0);
      tick();
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = '0;
      for (int i = 0; i <= 11; i++) mem[i] = word_t'(i);
      for (int i = 1; i <= 8; i++) mem[11+i] = word_t'(i) << 12;
      mem[8191] = 16'hBEEF;

      rst_n          = 1'b0;
      fetch_en       = 1'b1;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (3) tick();
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_addra", 32'(addra), 32'd0);
      chk("rst_data", 32'(instr_data), 32'd0);
      chk("rst_pc", 32'(instr_pc), 32'd0);

      // Release, then first word appears on the third cycle with no gaps after it.
      rst_n = 1'b1;
      tick();
      chk("lat_c1", 32'(instr_valid), 32'd0);
      tick();
      chk("lat_c2", 32'(instr_valid), 32'd0);
      tick();
      expect_seq(13'd0, 12);

      // Backpressure on word 2 for five cycles.
      do_redirect(13'd0);
      expect_seq(13'd0, 2);
      expect_one(13'd2);
      instr_ready = 1'b0;
      for (int i = 1; i < 5; i++) begin
         tick();
         expect_one(13'd2);
      end
      tick();
      instr_ready = 1'b1;
      expect_seq(13'd2, 3);

      // Redirect in the same cycle word 5 is accepted.
      expect_one(13'd5);
      do_redirect(13'd12);
      expect_seq(13'd12, 8);

      // Back-to-back redirects; the second one (to the wrap point) wins.
      redirect_valid = 1'b1;
      redirect_pc    = 13'd100;
      tick();
      redirect_pc    = 13'd8191;
      tick();
      redirect_valid = 1'b0;
      chk("b2b_addra", 32'(addra), 32'd8191);
      chk("b2b_gap1", 32'(instr_valid), 32'd0);
      tick();
      chk("b2b_gap2", 32'(instr_valid), 32'd0);
      tick();
      expect_seq(13'd8191, 3);

      // fetch_en low for four cycles: in-flight word 3 still arrives, addra frozen at 4.
      expect_one(13'd2);
      chk("hold_addra0", 32'(addra), 32'd4);
      fetch_en = 1'b0;
      tick();
      expect_one(13'd3);
      chk("hold_addra1", 32'(addra), 32'd4);
      tick();
      chk("hold_valid2", 32'(instr_valid), 32'd0);
      chk("hold_addra2", 32'(addra), 32'd4);
      tick();
      chk("hold_valid3", 32'(instr_valid), 32'd0);
      chk("hold_addra3", 32'(addra), 32'd4);
      tick();
      chk("hold_valid4", 32'(instr_valid), 32'd0);
      chk("hold_addra4", 32'(addra), 32'd4);
      fetch_en = 1'b1;
      tick();
      chk("resume_gap", 32'(instr_valid), 32'd0);
      tick();
      expect_seq(13'd4, 3);

      // Fill the buffer under backpressure, then reset mid-cycle.
      expect_one(13'd7);
      instr_ready = 1'b0;
      repeat (3) begin
         tick();
         expect_one(13'd7);
      end
      chk("full_addra", 32'(addra), 32'd10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(instr_valid), 32'd0);
      chk("arst_addra", 32'(addra), 32'd0);
      chk("arst_data", 32'(instr_data), 32'd0);
      chk("arst_pc", 32'(instr_pc), 32'd0);
      tick();
      tick();
      instr_ready = 1'b1;
      rst_n       = 1'b1;
      tick();
      chk("relat_c1", 32'(instr_valid), 32'd0);
      tick();
      chk("relat_c2", 32'(instr_valid), 32'd0);
      tick();
      expect_seq(13'd0, 4);

      chk("no_overflow", 32'(ovf_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage for the processor-2v stack core; sits directly upstream of blockmemory16kx1 (drives addra, consumes douta).
- Keeps the PC, issues one read per cycle, and tracks in-flight reads across the fixed synchronous memory latency.
- Buffers returned words so decode can apply backpressure.
- Handles jump/branch redirects by flushing stale fetches.

Parameters:
- ADDR_W, 13, PC/memory address width.
- DATA_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- MEM_LAT, 1, cycles from addra to valid douta (legal values 1..2).
- Derived localparam DEPTH = MEM_LAT+2: buffer depth, sized for 1 instr/cycle sustained throughput.

Ports:
- clka  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permits new fetch issue.
- redirect_valid  in  1  load new PC and flush (one-cycle pulse).
- redirect_pc  in  ADDR_W  target PC.
- addra  out  ADDR_W  memory address; registered, equals pc.
- douta  in  DATA_W  memory read data.
- instr_valid  out  1  instr_data/instr_pc valid.
- instr_ready  in  1  downstream accepts.
- instr_data  out  DATA_W  instruction word.
- instr_pc  out  ADDR_W  address instr_data was fetched from.

Behaviour:
- Reset (async assert, sync release): pc = addra = RESET_PC, all in-flight valid bits = 0, buffer empty, instr_valid = 0. instr_data and instr_pc = 0.
- Issue condition, evaluated each cycle: issue = fetch_en && !redirect_valid && (buf_count + inflight_count < DEPTH).
  - On issue: at the clock edge, pc <= pc+1 (mod 2^ADDR_W, so 8191 wraps to 0).
  - The current pc and a valid bit enter a MEM_LAT-deep tag shift register.
  - When issue=0, pc holds. The memory still reads addra, but the tag valid bit is 0.
- Return path:
  - When a tag exits the shift register with valid=1, douta and the tag pc are pushed into the buffer on that edge.
  - The credit rule guarantees the buffer is never full when a valid return arrives. An overflow is a design error; the bench asserts on it.
- Output:
  - instr_valid = buffer non-empty. Head is shown on instr_data/instr_pc.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle are legal at any occupancy.
  - While instr_valid=1 && instr_ready=0, outputs are stable.
- Redirect in cycle t:
  - A transfer handshaking in cycle t completes normally.
  - At edge t+1, all remaining buffer entries and all in-flight tag valid bits are cleared, and pc <= redirect_pc.
  - addra = redirect_pc during t+1. The first new instruction is valid in cycle t+MEM_LAT+2.
  - Redirect overrides fetch_en. Back-to-back redirects: the last one wins.
- Latency: reset release (or redirect) to first instr_valid = MEM_LAT+2 cycles. Steady-state throughput is 1 instr/cycle with instr_ready held high.
- fetch_en low: no new issues; in-flight reads still land in the buffer; addra holds.
- Reset mid-operation: everything returns to reset values immediately, regardless of buffer or in-flight state.
- The memory write port is not driven by this block; wea stays 0 during fetch.

Decomposition:
- Shared package proc2v_pkg: ADDR_W, DATA_W, RESET_PC, MEM_LAT constants; pc_t (ADDR_W-bit) and word_t (DATA_W-bit) typedefs.
- One sub-module: fetch_buf_fifo, a synchronous FIFO.
  - Parameters: DEPTH and entry width DATA_W+ADDR_W.
  - Ports: push, pop, flush, count, empty.
  - Async active-low reset.

Test Plan:
Bench instantiates blockmemory16kx1 initialised with word i = i for i = 0..11 and word 11+i = i<<12 for i = 1..8; MEM_LAT=1.
1. Release reset, fetch_en=1, instr_ready=1 -> instr_valid first high 3 cycles after release; data/pc 0/0, 1/1, ... 11/11 on consecutive cycles; no gaps.
2. Backpressure: drop instr_ready for 5 cycles after data 2 is presented -> data 2/pc 2 held stable all 5 cycles; then 2,3,4,... with no loss or duplicates; FIFO never overflows.
3. Redirect to pc 12 in the cycle data 5 is accepted -> 5 consumed; instr_valid low for 2 cycles; then 0x1000/12, 0x2000/13, ... 0x8000/19.
4. Wrap: redirect to 8191 -> instr_pc sequence 8191, 0, 1 with data matching memory.
5. Assert rst_n low mid-cycle with buffer full and ready=0 -> instr_valid=0 and addra=0 immediately (before the next clka edge); after release, resumes as scenario 1.
6. fetch_en low for 4 cycles mid-stream -> in-flight word still delivered; addra constant; no extra instructions; resumes with the next sequential pc when fetch_en returns high.
